// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter.
// State encoding, default sizes and a constant clog2.
package uart_tx_arb_pkg;

  localparam int NUM_REQ_DEF       = 4;
  localparam int START_TIMEOUT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    LAUNCH     = 2'b01,
    WAIT_START = 2'b10,
    WAIT_DONE  = 2'b11
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_rr_pick.sv
// Rotating priority encoder: first set request after i_last.
// Purely combinational; i_last itself has the lowest priority.
module uart_tx_rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  localparam int GW      = (clog2(NUM_REQ) > 0) ? clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [GW-1:0]      i_last,
  output logic               o_valid,
  output logic [GW-1:0]      o_winner
);

  logic [GW:0] w_sum;

  // Scan farthest offset first so the nearest hit overwrites it.
  always_comb begin
    o_valid  = 1'b0;
    o_winner = i_last;
    w_sum    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_sum = {1'b0, i_last} + (GW+1)'(i);
      if (w_sum >= (GW+1)'(NUM_REQ))
        w_sum = w_sum - (GW+1)'(NUM_REQ);
      if (i_req[w_sum[GW-1:0]]) begin
        o_valid  = 1'b1;
        o_winner = w_sum[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter.
// Latches the winner's byte/parity, launches, tracks TX_BUSY.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter  int NUM_REQ       = NUM_REQ_DEF,
  parameter  int DATA_WIDTH    = 8,
  parameter  int START_TIMEOUT = START_TIMEOUT_DEF,
  localparam int GW = (clog2(NUM_REQ) > 0) ? clog2(NUM_REQ) : 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ_VLD,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]            REQ_PAR_EN,
  input  logic [NUM_REQ-1:0]            REQ_PAR_TYP,
  output logic [NUM_REQ-1:0]            REQ_ACK,
  input  logic                          TX_BUSY,
  output logic [DATA_WIDTH-1:0]         TX_DATA,
  output logic                          TX_DATA_VLD,
  output logic                          TX_PAR_EN,
  output logic                          TX_PAR_TYP,
  output logic [GW-1:0]                 GRANT_ID,
  output logic                          ARB_BUSY,
  output logic                          FRAME_DONE,
  output logic                          START_ERR
);

  localparam int CW = clog2(START_TIMEOUT + 1);

  arb_state_e              r_state, w_next;
  logic [CW-1:0]           r_cnt;
  logic [GW-1:0]           r_last, r_gid;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_par_en, r_par_typ;
  logic                    r_frame_done, r_start_err;
  logic                    w_grant, w_done, w_timeout;
  logic                    w_pick_vld;
  logic [GW-1:0]           w_pick;
  logic [NUM_REQ-1:0]      w_ack;

  uart_tx_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req    (REQ_VLD),
    .i_last   (r_last),
    .o_valid  (w_pick_vld),
    .o_winner (w_pick)
  );

  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_done    = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_vld && !TX_BUSY) begin
          w_next  = LAUNCH;
          w_grant = 1'b1;
        end
      end
      LAUNCH: w_next = WAIT_START;
      WAIT_START: begin
        if (TX_BUSY) begin
          w_next = WAIT_DONE;
        end else if (r_cnt == CW'(START_TIMEOUT - 1)) begin
          w_next    = IDLE;
          w_timeout = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!TX_BUSY) begin
          w_next = IDLE;
          w_done = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_last       <= GW'(NUM_REQ - 1);
      r_gid        <= '0;
      r_data       <= '0;
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_frame_done <= 1'b0;
      r_start_err  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= (r_state == WAIT_START) ? r_cnt + 1'b1 : '0;
      r_frame_done <= w_done;
      r_start_err  <= w_timeout;
      if (w_grant) begin
        r_last    <= w_pick;
        r_gid     <= w_pick;
        r_data    <= REQ_DATA[int'(w_pick)*DATA_WIDTH +: DATA_WIDTH];
        r_par_en  <= REQ_PAR_EN[w_pick];
        r_par_typ <= REQ_PAR_TYP[w_pick];
      end
    end
  end

  always_comb begin
    w_ack = '0;
    if (r_state == LAUNCH) w_ack[r_gid] = 1'b1;
  end

  assign REQ_ACK     = w_ack;
  assign TX_DATA     = r_data;
  assign TX_DATA_VLD = (r_state == LAUNCH);
  assign TX_PAR_EN   = r_par_en;
  assign TX_PAR_TYP  = r_par_typ;
  assign GRANT_ID    = r_gid;
  assign ARB_BUSY    = (r_state != IDLE);
  assign FRAME_DONE  = r_frame_done;
  assign START_ERR   = r_start_err;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares the single UART transmitter between NUM_REQ byte requesters. It selects one pending requester, latches its byte and per-requester parity configuration, and launches the frame with a one-cycle DATA_VLD pulse. It then tracks the transmitter's BUSY through the frame and releases the link for the next grant. It sits between client logic (register bank, message sequencers) and the TX FSM/serializer/parity/mux datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width forwarded to transmitter
START_TIMEOUT, 4, cycles allowed from DATA_VLD pulse to TX_BUSY rising before abort

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous active-low reset
REQ_VLD  in  NUM_REQ  per-requester byte pending; held until matching REQ_ACK
REQ_DATA  in  NUM_REQ*DATA_WIDTH  packed bytes, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
REQ_PAR_EN  in  NUM_REQ  per-requester parity enable
REQ_PAR_TYP  in  NUM_REQ  per-requester parity type, 0 even / 1 odd
REQ_ACK  out  NUM_REQ  one-cycle pulse: byte of requester i accepted
TX_BUSY  in  1  BUSY from the transmitter FSM
TX_DATA  out  DATA_WIDTH  byte to the transmitter
TX_DATA_VLD  out  1  one-cycle launch pulse
TX_PAR_EN  out  1  parity enable to the transmitter
TX_PAR_TYP  out  1  parity type to the transmitter
GRANT_ID  out  clog2(NUM_REQ)  index of current/last granted requester
ARB_BUSY  out  1  high whenever not in IDLE
FRAME_DONE  out  1  one-cycle pulse when TX_BUSY falls at end of a frame
START_ERR  out  1  one-cycle pulse on start timeout

Behaviour:
- Reset (RST=0, async): state IDLE; all outputs 0; GRANT_ID=0; RR pointer last=NUM_REQ-1, so requester 0 has top priority first; timeout counter 0.
- States: IDLE, LAUNCH, WAIT_START, WAIT_DONE. All outputs registered or decoded from state only; no combinational path from REQ_* to outputs.
- IDLE: if any REQ_VLD=1 and TX_BUSY=0, pick the first set bit scanning last+1, last+2, ... (mod NUM_REQ). At the clock edge:
  - latch TX_DATA, TX_PAR_EN, TX_PAR_TYP and GRANT_ID from the winner;
  - set last=winner;
  - go to LAUNCH.
  If TX_BUSY=1 in IDLE, stay; no grant.
- LAUNCH (exactly 1 cycle): TX_DATA_VLD=1 and REQ_ACK[GRANT_ID]=1 in the same cycle. Next state WAIT_START; counter cleared.
- WAIT_START: TX_BUSY=1 -> WAIT_DONE. Otherwise count; when count reaches START_TIMEOUT with TX_BUSY still 0, pulse START_ERR and return to IDLE. The byte is lost and not re-queued.
- WAIT_DONE: stay while TX_BUSY=1. TX_BUSY=0 -> pulse FRAME_DONE and go to IDLE. A new grant is possible on the following cycle.
- TX_DATA, TX_PAR_EN, TX_PAR_TYP and GRANT_ID are held constant from the latch edge until the next grant, so parity config is stable for the whole frame.
- Requester changes to REQ_DATA/REQ_PAR_* after the latch edge have no effect on the frame in flight. A REQ_VLD drop before grant withdraws the request with no ack.
- Grant rules:
  - a single requester gets back-to-back grants;
  - with all requesting, order is 0,1,2,3,0,...;
  - no requester waits more than NUM_REQ-1 frames.
- TX_BUSY glitching high in IDLE or LAUNCH is ignored except as the IDLE grant block.

Decomposition:
- Package uart_tx_arb_pkg: state encoding localparams (IDLE=2'b00, LAUNCH=2'b01, WAIT_START=2'b10, WAIT_DONE=2'b11), default NUM_REQ/START_TIMEOUT, clog2 helper.
- Sub-module uart_tx_rr_pick: combinational rotate-priority-encoder with inputs req vector and last index, outputs valid and winner index. The FSM, latches and counter stay in the top.

Test Plan:
- Reset then REQ_VLD=4'b0001, REQ_DATA[7:0]=8'hA5, PAR_EN=1, TYP=0, TX model raises BUSY 1 cycle after DATA_VLD for 11 cycles -> TX_DATA=8'hA5, TX_PAR_EN=1 and one TX_DATA_VLD pulse, REQ_ACK=4'b0001 in the same cycle, FRAME_DONE 1 cycle after BUSY falls.
- REQ_VLD=4'b1111 held for 8 frames -> GRANT_ID sequence 0,1,2,3,0,1,2,3, each requester acked exactly twice.
- Requester 2 alone, continuously valid -> consecutive grants to 2 with exactly one IDLE cycle between FRAME_DONE and the next latch.
- TX model never raises BUSY -> START_ERR pulses START_TIMEOUT cycles after WAIT_START entry, return to IDLE, next pending requester is granted.
- RST low mid-WAIT_DONE -> all outputs 0 immediately; after release requester 0 wins over pending 3.
- TX_BUSY held 1 with REQ_VLD=4'b0100 -> no TX_DATA_VLD and no REQ_ACK until BUSY=0, then grant to 2.
